// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: captures {pcnext, instruction} from fetch and hands entries to decode.
// PCWrite throttles fetch when full; a taken branch (flush) discards every buffered entry.
module if_id_buffer #(
  parameter int PC_WIDTH  = 6,
  parameter int DEPTH     = 2,
  parameter int PTR_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  if_pcnext,
  input  logic [31:0]          if_instruction,
  output logic                 PCWrite,
  input  logic                 flush,
  output logic                 id_valid,
  output logic [31:0]          id_instruction,
  output logic [PC_WIDTH-1:0]  id_pcnext,
  input  logic                 id_ready,
  output logic [PTR_WIDTH:0]   count
);

  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);

  logic [PC_WIDTH-1:0]  pc_mem  [DEPTH];
  logic [31:0]          ins_mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  // PCWrite depends only on registered occupancy and flush, never on id_ready
  assign PCWrite  = (count != FULL) || flush;
  assign id_valid = (count != '0);
  assign push     = PCWrite && !flush;
  assign pop      = id_valid && id_ready;

  always_comb begin
    id_instruction = '0;
    id_pcnext      = '0;
    if (id_valid) begin
      id_instruction = ins_mem[rd_ptr];
      id_pcnext      = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= if_pcnext;
      ins_mem[wr_ptr] <= if_instruction;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_WIDTH + 1)'(1);
        2'b01:   count <= count - (PTR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: streaming, backpressure, flush, wrap, async reset,
// and flush coinciding with a completed handshake.
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic [5:0]  if_pcnext;
  logic [31:0] if_instruction;
  logic        PCWrite;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [5:0]  id_pcnext;
  logic        id_ready;
  logic [1:0]  count;

  int checks;
  int failures;

  if_id_buffer #(.PC_WIDTH(6), .DEPTH(2), .PTR_WIDTH(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pcnext      (if_pcnext),
    .if_instruction (if_instruction),
    .PCWrite        (PCWrite),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pcnext      (id_pcnext),
    .id_ready       (id_ready),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [5:0] pc);
    return 32'hC0DE_0000 | {26'd0, pc};
  endfunction

  task automatic drive(input logic [5:0] pc);
    if_pcnext      = pc + 6'd4;
    if_instruction = instr_of(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    drive(6'd0);
    tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    drive(6'd0);
    tick;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%b exp=0", id_valid); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", count); end
    checks++; if (PCWrite !== 1'b1) begin failures++; $display("FAIL reset_pcwrite act=%b exp=1", PCWrite); end
    checks++; if (id_instruction !== 32'd0) begin failures++; $display("FAIL reset_instr act=%h exp=0", id_instruction); end
    checks++; if (id_pcnext !== 6'd0) begin failures++; $display("FAIL reset_pcnext act=%0d exp=0", id_pcnext); end
    rst = 1'b1;
  endtask

  task automatic test_stream;
    logic [5:0] pc;
    do_reset;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 6'(4 * i);
      drive(pc);
      checks++; if (PCWrite !== 1'b1) begin failures++; $display("FAIL stream_pcwrite i=%0d act=%b exp=1", i, PCWrite); end
      tick;
      checks++; if (count !== 2'd1) begin failures++; $display("FAIL stream_count i=%0d act=%0d exp=1", i, count); end
      checks++; if (id_pcnext !== pc + 6'd4) begin failures++; $display("FAIL stream_pcnext i=%0d act=%0d exp=%0d", i, id_pcnext, pc + 6'd4); end
      checks++; if (id_instruction !== instr_of(pc)) begin failures++; $display("FAIL stream_instr i=%0d act=%h exp=%h", i, id_instruction, instr_of(pc)); end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    drive(6'd0);
    tick;
    checks++; if (count !== 2'd1 || PCWrite !== 1'b1) begin failures++; $display("FAIL bp_one act=%0d/%b exp=1/1", count, PCWrite); end
    drive(6'd4);
    tick;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL bp_full_count act=%0d exp=2", count); end
    checks++; if (PCWrite !== 1'b0) begin failures++; $display("FAIL bp_full_pcwrite act=%b exp=0", PCWrite); end
    checks++; if (id_pcnext !== 6'd4) begin failures++; $display("FAIL bp_head act=%0d exp=4", id_pcnext); end
    drive(6'd8);
    tick;
    checks++; if (count !== 2'd2 || id_pcnext !== 6'd4) begin failures++; $display("FAIL bp_hold act=%0d/%0d exp=2/4", count, id_pcnext); end
    id_ready = 1'b1;
    tick;
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL bp_pop1_count act=%0d exp=1", count); end
    checks++; if (PCWrite !== 1'b1) begin failures++; $display("FAIL bp_pop1_pcwrite act=%b exp=1", PCWrite); end
    checks++; if (id_pcnext !== 6'd8) begin failures++; $display("FAIL bp_pop1_head act=%0d exp=8", id_pcnext); end
    tick;
    checks++; if (count !== 2'd1 || id_pcnext !== 6'd12) begin failures++; $display("FAIL bp_push12 act=%0d/%0d exp=1/12", count, id_pcnext); end
    checks++; if (id_instruction !== instr_of(6'd8)) begin failures++; $display("FAIL bp_push12_instr act=%h exp=%h", id_instruction, instr_of(6'd8)); end
  endtask

  task automatic test_flush;
    do_reset;
    drive(6'd0);
    tick;
    drive(6'd4);
    tick;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre_count act=%0d exp=2", count); end
    drive(6'd12);
    flush = 1'b1;
    #1;
    checks++; if (PCWrite !== 1'b1) begin failures++; $display("FAIL flush_pcwrite act=%b exp=1", PCWrite); end
    tick;
    flush = 1'b0;
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count act=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0 || id_pcnext !== 6'd0) begin failures++; $display("FAIL flush_empty act=%b/%0d exp=0/0", id_valid, id_pcnext); end
    drive(6'd40);
    tick;
    checks++; if (count !== 2'd1 || id_pcnext !== 6'd44) begin failures++; $display("FAIL flush_target act=%0d/%0d exp=1/44", count, id_pcnext); end
    checks++; if (id_instruction !== instr_of(6'd40)) begin failures++; $display("FAIL flush_target_instr act=%h exp=%h", id_instruction, instr_of(6'd40)); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] pc;
    do_reset;
    drive(6'd0);
    tick;
    id_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      pc = 6'(4 * i);
      drive(pc);
      tick;
      checks++; if (count !== 2'd1) begin failures++; $display("FAIL b2b_count i=%0d act=%0d exp=1", i, count); end
      checks++; if (id_pcnext !== pc + 6'd4) begin failures++; $display("FAIL b2b_pcnext i=%0d act=%0d exp=%0d", i, id_pcnext, pc + 6'd4); end
      checks++; if (id_instruction !== instr_of(pc)) begin failures++; $display("FAIL b2b_instr i=%0d act=%h exp=%h", i, id_instruction, instr_of(pc)); end
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    drive(6'd0);
    tick;
    drive(6'd4);
    tick;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL areset_pre act=%0d exp=2", count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL areset_valid act=%b exp=0", id_valid); end
    checks++; if (id_instruction !== 32'd0) begin failures++; $display("FAIL areset_instr act=%h exp=0", id_instruction); end
    checks++; if (PCWrite !== 1'b1 || count !== 2'd0) begin failures++; $display("FAIL areset_state act=%b/%0d exp=1/0", PCWrite, count); end
    tick;
    rst = 1'b1;
    drive(6'd0);
    tick;
    checks++; if (count !== 2'd1 || id_pcnext !== 6'd4) begin failures++; $display("FAIL areset_first act=%0d/%0d exp=1/4", count, id_pcnext); end
  endtask

  task automatic test_flush_handshake;
    do_reset;
    drive(6'd0);
    tick;
    checks++; if (id_valid !== 1'b1 || id_pcnext !== 6'd4) begin failures++; $display("FAIL fh_pre act=%b/%0d exp=1/4", id_valid, id_pcnext); end
    id_ready = 1'b1;
    flush = 1'b1;
    drive(6'd4);
    tick;
    flush = 1'b0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL fh_empty act=%0d/%b exp=0/0", count, id_valid); end
    drive(6'd20);
    tick;
    checks++; if (count !== 2'd1 || id_pcnext !== 6'd24) begin failures++; $display("FAIL fh_target act=%0d/%0d exp=1/24", count, id_pcnext); end
    id_ready = 1'b0;
    drive(6'd24);
    tick;
    checks++; if (count !== 2'd2 || id_pcnext !== 6'd24) begin failures++; $display("FAIL fh_nodup act=%0d/%0d exp=2/24", count, id_pcnext); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    drive(6'd0);
    #2;
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_back_to_back;
    test_async_reset;
    test_flush_handshake;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
